// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: L1 miss-fill controller. Freezes the pipeline on a miss,
// streams one block in from multi-cycle memory as pipelined word reads,
// writes each returned word into the data array, then writes the tag.
// Optional build macro: CACHE_CRITICAL_WORD_FIRST_EN (issue and write the
// missing word first, wrapping around the block).
module cache_fill_fsm #(
  parameter int unsigned ADDR_W          = 16,
  parameter int unsigned WORDS_PER_BLOCK = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic              memory_data_valid,
  input  logic [15:0]       memory_data,
  output logic              mem_read_en,
  output logic [ADDR_W-1:0] memory_address,
  output logic              write_data_array,
  output logic [ADDR_W-1:0] data_array_addr,
  output logic [15:0]       data_array_wdata,
  output logic              write_tag_array,
  output logic              fsm_busy,
  output logic              cache_stall_n
);

  localparam int unsigned IDX_W = $clog2(WORDS_PER_BLOCK);
  localparam int unsigned CNT_W = IDX_W + 1;
  // byte offset bits inside a block of 16-bit words
  localparam int unsigned OFF_W = IDX_W + 1;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t             state_q, state_nxt;
  logic [ADDR_W-1:0]  base_q, base_nxt;
  logic [CNT_W-1:0]   issue_cnt_q, issue_cnt_nxt;
  logic [CNT_W-1:0]   recv_cnt_q, recv_cnt_nxt;
  logic [IDX_W-1:0]   issue_idx, recv_idx;
  logic               issue_pending;
  logic               recv_last;
  logic               miss_lo_unused;

  // Low address bits only select the word inside the block; in the linear
  // build they carry no information the controller needs.
  assign miss_lo_unused = ^miss_address[OFF_W-1:0];

`ifdef CACHE_CRITICAL_WORD_FIRST_EN
  logic [IDX_W-1:0]   start_q, start_nxt;

  // Word order rotates so the missing word is first; wraps within the block.
  assign issue_idx = start_q + issue_cnt_q[IDX_W-1:0];
  assign recv_idx  = start_q + recv_cnt_q[IDX_W-1:0];

  // Critical-word start index, latched with the block base at miss time.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      start_q <= '0;
    end else begin
      start_q <= start_nxt;
    end
  end

  // Start index follows the missing word on a new miss, otherwise holds.
  always_comb begin
    start_nxt = start_q;
    if (state_q == IDLE && miss_detected) begin
      start_nxt = miss_address[OFF_W-1:1];
    end
  end
`else
  // Linear order from the start of the block.
  assign issue_idx = issue_cnt_q[IDX_W-1:0];
  assign recv_idx  = recv_cnt_q[IDX_W-1:0];
`endif

  assign issue_pending = (issue_cnt_q < CNT_W'(WORDS_PER_BLOCK));
  assign recv_last     = (recv_cnt_q == CNT_W'(WORDS_PER_BLOCK - 1));

  // Block base plus word offset; base is aligned so this never leaves the block.
  function automatic logic [ADDR_W-1:0] word_addr(
    input logic [ADDR_W-1:0] base,
    input logic [IDX_W-1:0]  idx
  );
    return base + ADDR_W'({idx, 1'b0});
  endfunction

  // State and fill bookkeeping registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      base_q      <= '0;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
    end else begin
      state_q     <= state_nxt;
      base_q      <= base_nxt;
      issue_cnt_q <= issue_cnt_nxt;
      recv_cnt_q  <= recv_cnt_nxt;
    end
  end

  // Next-state, memory issue and array write strobes.
  always_comb begin
    state_nxt        = state_q;
    base_nxt         = base_q;
    issue_cnt_nxt    = issue_cnt_q;
    recv_cnt_nxt     = recv_cnt_q;
    mem_read_en      = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    data_array_addr  = '0;
    data_array_wdata = '0;
    write_tag_array  = 1'b0;
    fsm_busy         = 1'b0;

    case (state_q)
      IDLE: begin
        // returning data is meaningless here and is dropped
        if (miss_detected) begin
          base_nxt      = {miss_address[ADDR_W-1:OFF_W], OFF_W'(0)};
          issue_cnt_nxt = '0;
          recv_cnt_nxt  = '0;
          state_nxt     = FILL;
        end
      end

      FILL: begin
        fsm_busy = 1'b1;
        // issue side: one read per cycle until the whole block is requested
        if (issue_pending) begin
          mem_read_en    = 1'b1;
          memory_address = word_addr(base_q, issue_idx);
          issue_cnt_nxt  = issue_cnt_q + CNT_W'(1);
        end
        // receive side: independent of issue, tolerates gaps in valid
        if (memory_data_valid) begin
          write_data_array = 1'b1;
          data_array_addr  = word_addr(base_q, recv_idx);
          data_array_wdata = memory_data;
          recv_cnt_nxt     = recv_cnt_q + CNT_W'(1);
          if (recv_last) begin
            write_tag_array = 1'b1;
            state_nxt       = IDLE;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Pipeline write enable; low on the miss cycle itself and for the whole fill.
  assign cache_stall_n = ~(fsm_busy | miss_detected);

endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb_cache_fill_fsm: directed plus randomized checks of cache_fill_fsm against
// a queue-based reference model of the block fill.
module tb_cache_fill_fsm;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned WPB    = 8;

  logic              clk;
  logic              rst_n;
  logic              miss_detected;
  logic [ADDR_W-1:0] miss_address;
  logic              memory_data_valid;
  logic [15:0]       memory_data;
  logic              mem_read_en;
  logic [ADDR_W-1:0] memory_address;
  logic              write_data_array;
  logic [ADDR_W-1:0] data_array_addr;
  logic [15:0]       data_array_wdata;
  logic              write_tag_array;
  logic              fsm_busy;
  logic              cache_stall_n;

  cache_fill_fsm #(.ADDR_W(ADDR_W), .WORDS_PER_BLOCK(WPB)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data_valid (memory_data_valid),
    .memory_data       (memory_data),
    .mem_read_en       (mem_read_en),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .data_array_addr   (data_array_addr),
    .data_array_wdata  (data_array_wdata),
    .write_tag_array   (write_tag_array),
    .fsm_busy          (fsm_busy),
    .cache_stall_n     (cache_stall_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // reference model: lists of addresses still to be issued / still to be written
  bit          known  = 1'b0;
  bit          m_busy = 1'b0;
  logic [15:0] iss_q[$];
  logic [15:0] rcv_q[$];
  // memory model: cycle at which each outstanding read returns
  int          due_q[$];
  int          cyc     = 0;
  int          latency = 4;
  int          mode    = 0;   // 0: latency memory, 1: scripted valid pattern
  int          gap     = 0;
  bit          pat[$];
  // observed activity, compared against constants after each scenario
  logic [15:0] ilog[$];
  logic [15:0] wlog[$];
  int          tag_at[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int start_word(input logic [15:0] ma);
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
    return int'(ma[3:1]);
`else
    return 0 * int'(ma[0]);
`endif
  endfunction

  function automatic logic [15:0] order_addr(input logic [15:0] ma, input int k);
    return (ma & 16'hFFF0) + 16'(((start_word(ma) + k) % 8) * 2);
  endfunction

  task automatic start_fill(input logic [15:0] ma);
    iss_q.delete();
    rcv_q.delete();
    for (int k = 0; k < int'(WPB); k++) begin
      iss_q.push_back(order_addr(ma, k));
      rcv_q.push_back(order_addr(ma, k));
    end
    m_busy = 1'b1;
  endtask

  task automatic clear_logs();
    ilog.delete();
    wlog.delete();
    tag_at.delete();
  endtask

  // One clock: drive at negedge, check at negedge+1, advance model at posedge.
  task automatic step(input bit miss, input logic [15:0] ma, input bit rst);
    bit v;
    bit e_rd;
    bit e_wr;
    bit e_tag;
    rst_n         = rst;
    miss_detected = miss;
    miss_address  = ma;
    v = 1'b0;
    if (mode == 0) begin
      if (due_q.size() > 0 && due_q[0] <= cyc) v = (gap == 0) || ($urandom_range(3) != 0);
    end else if (pat.size() > 0) begin
      v = pat.pop_front();
    end
    memory_data_valid = v;
    memory_data       = 16'($urandom);
    #1;
    if (known) begin
      e_rd  = m_busy && iss_q.size() > 0;
      e_wr  = m_busy && v;
      e_tag = e_wr && rcv_q.size() == 1;
      chk("fsm_busy", 32'(fsm_busy), 32'(m_busy));
      chk("cache_stall_n", 32'(cache_stall_n), 32'(!(m_busy || miss)));
      chk("mem_read_en", 32'(mem_read_en), 32'(e_rd));
      if (e_rd) chk("memory_address", 32'(memory_address), 32'(iss_q[0]));
      chk("write_data_array", 32'(write_data_array), 32'(e_wr));
      if (e_wr) begin
        chk("data_array_addr", 32'(data_array_addr), 32'(rcv_q[0]));
        chk("data_array_wdata", 32'(data_array_wdata), 32'(memory_data));
      end
      chk("write_tag_array", 32'(write_tag_array), 32'(e_tag));
    end
    if (mem_read_en === 1'b1) ilog.push_back(memory_address);
    if (write_data_array === 1'b1) wlog.push_back(data_array_addr);
    if (write_tag_array === 1'b1) tag_at.push_back(wlog.size());
    @(posedge clk);
    if (!rst) begin
      m_busy = 1'b0;
      iss_q.delete();
      rcv_q.delete();
      due_q.delete();
      known = 1'b1;
    end else if (!m_busy) begin
      if (miss) start_fill(ma);
    end else begin
      if (iss_q.size() > 0) begin
        void'(iss_q.pop_front());
        due_q.push_back(cyc + latency);
      end
      if (v) begin
        void'(rcv_q.pop_front());
        if (mode == 0) void'(due_q.pop_front());
        if (rcv_q.size() == 0) m_busy = 1'b0;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  // Miss cycle then clock until the model goes idle, bounded by budget.
  task automatic run_fill(input logic [15:0] ma, input bit dmiss, input logic [15:0] daddr,
                          input int budget);
    int n;
    n = 0;
    step(1'b1, ma, 1'b1);
    while (m_busy && n < budget) begin
      step(dmiss, daddr, 1'b1);
      n++;
    end
    chk("fill_done_in_budget", 32'(m_busy), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n             = 1'b0;
    miss_detected     = 1'b1;
    miss_address      = 16'h1236;
    memory_data_valid = 1'b1;
    memory_data       = 16'h0;
    @(negedge clk);

    // reset held two cycles with miss and valid active, then quiet idle cycle
    mode = 1;
    for (int i = 0; i < 3; i++) pat.push_back(1'b1);
    step(1'b1, 16'h1236, 1'b0);
    step(1'b1, 16'h1236, 1'b0);
    clear_logs();
    step(1'b0, 16'h0000, 1'b1);
    chk("reset_no_writes", 32'(wlog.size()), 32'(0));
    chk("reset_no_reads", 32'(ilog.size()), 32'(0));

    // single miss, 4-cycle memory
    mode = 0; latency = 4; gap = 0;
    clear_logs();
    run_fill(16'h1236, 1'b0, 16'h0, 40);
    chk("single_issue_count", 32'(ilog.size()), 32'(8));
    chk("single_write_count", 32'(wlog.size()), 32'(8));
    for (int k = 0; k < 8 && k < ilog.size() && k < wlog.size(); k++) begin
      chk("single_issue_addr", 32'(ilog[k]), 32'(order_addr(16'h1236, k)));
      chk("single_write_addr", 32'(wlog[k]), 32'(order_addr(16'h1236, k)));
    end
    chk("single_tag_count", 32'(tag_at.size()), 32'(1));
    if (tag_at.size() > 0) chk("single_tag_on_last", 32'(tag_at[0]), 32'(8));
    step(1'b0, 16'h0, 1'b1);

    // gapped returns from a scripted valid pattern
    mode = 1;
    clear_logs();
    step(1'b1, 16'h4A50, 1'b1);
    begin
      bit p [12] = '{1, 0, 1, 1, 0, 0, 1, 1, 1, 0, 1, 1};
      for (int i = 0; i < 12; i++) pat.push_back(p[i]);
    end
    for (int i = 0; i < 12; i++) step(1'b0, 16'h0, 1'b1);
    chk("gap_fill_done", 32'(m_busy), 32'(0));
    chk("gap_write_count", 32'(wlog.size()), 32'(8));
    chk("gap_tag_count", 32'(tag_at.size()), 32'(1));
    if (tag_at.size() > 0) chk("gap_tag_on_8th", 32'(tag_at[0]), 32'(8));
    step(1'b0, 16'h0, 1'b1);

    // reset in the middle of a fill, then stray valids
    mode = 0; latency = 4; gap = 0;
    clear_logs();
    step(1'b1, 16'h2000, 1'b1);
    for (int i = 0; i < 20 && wlog.size() < 3; i++) step(1'b0, 16'h0, 1'b1);
    chk("midreset_three_written", 32'(wlog.size()), 32'(3));
    mode = 1;
    step(1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 5; i++) pat.push_back(1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 16'h0, 1'b1);
    chk("midreset_no_tag", 32'(tag_at.size()), 32'(0));
    chk("midreset_no_stray_writes", 32'(wlog.size()), 32'(3));

    // back-to-back misses; miss held through fill and on the completion cycle
    mode = 0; latency = 4; gap = 0;
    clear_logs();
    run_fill(16'h0000, 1'b1, 16'h5550, 40);
    run_fill(16'hFFF0, 1'b0, 16'h0, 40);
    chk("b2b_issue_count", 32'(ilog.size()), 32'(16));
    for (int k = 0; k < 8 && 8 + k < ilog.size(); k++)
      chk("b2b_second_addr", 32'(ilog[8 + k]), 32'(16'hFFF0 + 16'(2 * k)));
    if (ilog.size() == 16) chk("b2b_top_no_wrap", 32'(ilog[15]), 32'(16'hFFFE));
    chk("b2b_tag_count", 32'(tag_at.size()), 32'(2));

    // critical-word-first ordering (linear order in the default build)
    latency = 3;
    clear_logs();
    run_fill(16'h123A, 1'b0, 16'h0, 40);
    chk("cwf_write_count", 32'(wlog.size()), 32'(8));
    if (wlog.size() == 8) begin
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
      chk("cwf_first_word", 32'(wlog[0]), 32'(16'h123A));
      chk("cwf_wrap_word", 32'(wlog[3]), 32'(16'h1230));
      chk("cwf_last_word", 32'(wlog[7]), 32'(16'h1238));
`else
      chk("cwf_first_word", 32'(wlog[0]), 32'(16'h1230));
      chk("cwf_last_word", 32'(wlog[7]), 32'(16'h123E));
`endif
    end
    if (tag_at.size() > 0) chk("cwf_tag_on_last", 32'(tag_at[0]), 32'(8));

    // randomized misses, latencies and return gaps
    for (int r = 0; r < 20; r++) begin
      latency = int'($urandom_range(6, 1));
      gap     = int'($urandom_range(1));
      for (int i = int'($urandom_range(2)); i > 0; i--) step(1'b0, 16'h0, 1'b1);
      run_fill(16'($urandom), 1'($urandom_range(1)), 16'($urandom), 200);
    end
    step(1'b0, 16'h0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
